// File: rtl/izh_mon_pkg.sv
// Shared constants and types for the Izhikevich spike monitor.
// Voltages are the neuron's Q2.6 word: 64 = 1.0, so 19 ~ 0.30 (30 mV).
package izh_mon_pkg;

    localparam logic signed [7:0] V_30MV     = 8'sd19;
    localparam logic signed [7:0] V_REARM    = -8'sd16;

    localparam logic signed [7:0] TH_HI_DEF  = V_30MV;
    localparam logic signed [7:0] TH_LO_DEF  = V_REARM;
    localparam int                ISI_W_DEF  = 16;
    localparam int                CNT_W_DEF  = 16;
    localparam int                FIFO_DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        REFRACT = 1'b1
    } mon_state_t;

endpackage

// File: rtl/izh_isi_fifo.sv
// Small synchronous FIFO holding inter-spike intervals.
// The head entry comes straight from the storage registers, so the output
// is stable while the consumer stalls. A push on a full FIFO is accepted
// only when a pop frees a slot in the same cycle; the parent decides what
// to do with a push that cannot be accepted.
module izh_isi_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & o_valid;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage, pointers and occupancy; clear empties the FIFO and zeroes the head.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/izh_spike_monitor.sv
// Spike detector, spike counter and inter-spike-interval recorder for the
// Izhikevich neuron's membrane-voltage word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ARMED   | waiting for v_in >= TH_HI; crossing it fires one spike
// REFRACT | spike fired; waiting for v_in < TH_LO before re-arming
//
// The ISI push is registered one cycle behind the detect so that isi_valid
// never rises in the same cycle as the spike pulse.
module izh_spike_monitor
    import izh_mon_pkg::*;
#(
    parameter logic signed [7:0] TH_HI      = TH_HI_DEF,
    parameter logic signed [7:0] TH_LO      = TH_LO_DEF,
    parameter int                ISI_W      = ISI_W_DEF,
    parameter int                CNT_W      = CNT_W_DEF,
    parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic signed [7:0] v_in,
    input  logic              clr,
    output logic              spike,
    output logic [CNT_W-1:0]  spike_count,
    output logic              isi_valid,
    output logic [ISI_W-1:0]  isi_data,
    input  logic              isi_ready,
    output logic              overflow
);

    mon_state_t       r_state;
    logic             r_spike;
    logic [CNT_W-1:0] r_spike_count;
    logic [ISI_W-1:0] r_isi_cnt;
    logic             r_have_prev;
    logic             r_push;
    logic [ISI_W-1:0] r_push_data;
    logic             r_overflow;

    logic             w_detect;
    logic [ISI_W-1:0] w_isi_inc;
    logic             w_full;
    logic             w_pop;
    logic             w_fifo_push;
    logic             w_drop;

    assign w_detect  = en && (r_state == ARMED) && (v_in >= TH_HI);
    assign w_isi_inc = (r_isi_cnt == '1) ? r_isi_cnt : r_isi_cnt + ISI_W'(1);

    assign w_pop       = isi_valid & isi_ready;
    assign w_fifo_push = r_push & (~w_full | w_pop);
    assign w_drop      = r_push & w_full & ~w_pop;

    // Hysteresis FSM with the registered one-cycle spike pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state <= ARMED;
            r_spike <= 1'b0;
        end else begin
            r_spike <= 1'b0;
            if (en) begin
                case (r_state)
                    ARMED: begin
                        if (v_in >= TH_HI) begin
                            r_spike <= 1'b1;
                            r_state <= REFRACT;
                        end
                    end
                    REFRACT: begin
                        if (v_in < TH_LO) begin
                            r_state <= ARMED;
                        end
                    end
                    default: r_state <= ARMED;
                endcase
            end
        end
    end

    // Spike counter, interval counter and the delayed ISI push request.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_spike_count <= '0;
            r_isi_cnt     <= '0;
            r_have_prev   <= 1'b0;
            r_push        <= 1'b0;
            r_push_data   <= '0;
        end else begin
            r_push <= 1'b0;
            if (en) begin
                if (w_detect) begin
                    r_spike_count <= (r_spike_count == '1) ? r_spike_count
                                                           : r_spike_count + CNT_W'(1);
                    r_isi_cnt     <= '0;
                    r_have_prev   <= 1'b1;
                    r_push        <= r_have_prev;
                    r_push_data   <= w_isi_inc;
                end else begin
                    r_isi_cnt <= w_isi_inc;
                end
            end
        end
    end

    // Sticky flag for an interval lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    izh_isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_isi_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (clr),
        .i_push      (w_fifo_push),
        .i_push_data (r_push_data),
        .o_full      (w_full),
        .i_pop       (isi_ready),
        .o_valid     (isi_valid),
        .o_data      (isi_data)
    );

    assign spike       = r_spike;
    assign spike_count = r_spike_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_izh_spike_monitor.sv
// Self-checking bench for izh_spike_monitor: a cycle model predicts the
// spike/count/overflow outputs and a scoreboard queue holds expected ISIs.
module tb_izh_spike_monitor;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic signed [7:0] v_in = '0;
    logic              clr = 1'b0;
    logic              spike;
    logic [15:0]       spike_count;
    logic              isi_valid;
    logic [15:0]       isi_data;
    logic              isi_ready = 1'b0;
    logic              overflow;

    izh_spike_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .v_in        (v_in),
        .clr         (clr),
        .spike       (spike),
        .spike_count (spike_count),
        .isi_valid   (isi_valid),
        .isi_data    (isi_data),
        .isi_ready   (isi_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state
    logic        m_state = 1'b0;
    logic        m_spike = 1'b0;
    logic [15:0] m_count = '0;
    logic [15:0] m_isi = '0;
    logic        m_have = 1'b0;
    logic        m_pend = 1'b0;
    logic [15:0] m_pend_val = '0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_fifo[$];

    int          n_spk = 0;
    int          n_pops = 0;
    logic [15:0] last_pop = '0;

    task automatic step(input logic e, input logic signed [7:0] v, input logic rdy,
                        input logic c, input logic rb);
        logic pop;
        logic full_pre;
        en = e; v_in = v; isi_ready = rdy; clr = c; rst_n = rb;
        pop      = rb && !c && (m_fifo.size() > 0) && rdy;
        full_pre = (m_fifo.size() == 4);
        if (isi_valid === 1'b1 && rdy) begin
            n_pops++;
            last_pop = isi_data;
        end
        if (pop) begin
            checks++;
            if (isi_data !== m_fifo[0]) begin
                errors++;
                $display("FAIL pop_data: got %0d expected %0d", isi_data, m_fifo[0]);
            end
        end
        if (!rb || c) begin
            m_state = 1'b0; m_spike = 1'b0; m_count = '0; m_isi = '0;
            m_have = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_fifo.delete();
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_pend) begin
                if (!full_pre || pop) m_fifo.push_back(m_pend_val);
                else m_ovf = 1'b1;
            end
            m_pend  = 1'b0;
            m_spike = 1'b0;
            if (e) begin
                if (m_state == 1'b0 && v >= 8'sd19) begin
                    m_spike = 1'b1;
                    if (m_count != 16'hFFFF) m_count++;
                    if (m_have) begin
                        m_pend = 1'b1;
                        m_pend_val = (m_isi == 16'hFFFF) ? m_isi : m_isi + 16'd1;
                    end
                    m_have  = 1'b1;
                    m_isi   = '0;
                    m_state = 1'b1;
                end else begin
                    if (m_isi != 16'hFFFF) m_isi++;
                    if (m_state == 1'b1 && v < -8'sd16) m_state = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (spike === 1'b1) n_spk++;
        checks++;
        if (spike !== m_spike) begin
            errors++;
            $display("FAIL spike: got %b expected %b at %0t", spike, m_spike, $time);
        end
        checks++;
        if (spike_count !== m_count) begin
            errors++;
            $display("FAIL spike_count: got %0d expected %0d at %0t", spike_count, m_count, $time);
        end
        checks++;
        if (isi_valid !== (m_fifo.size() > 0)) begin
            errors++;
            $display("FAIL isi_valid: got %b expected %b at %0t", isi_valid, (m_fifo.size() > 0), $time);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
        end
        if (m_fifo.size() > 0) begin
            checks++;
            if (isi_data !== m_fifo[0]) begin
                errors++;
                $display("FAIL head_data: got %0d expected %0d at %0t", isi_data, m_fifo[0], $time);
            end
        end
    endtask

    task automatic run(input int n, input logic e, input logic signed [7:0] v, input logic rdy);
        for (int i = 0; i < n; i++) step(e, v, rdy, 1'b0, 1'b1);
    endtask

    task automatic spike_train(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 8'sd25, rdy, 1'b0, 1'b1);
            run(4, 1'b1, -8'sd23, rdy);
        end
    endtask

    task automatic test_reset();
        int s0;
        step(1'b1, -8'sd23, 1'b0, 1'b0, 1'b0);
        checks++;
        if (isi_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_isi_data: got %0d expected 0", isi_data);
        end
        s0 = n_spk;
        run(50, 1'b1, -8'sd23, 1'b1);
        checks++;
        if (n_spk - s0 != 0) begin
            errors++;
            $display("FAIL quiet_spikes: got %0d expected 0", n_spk - s0);
        end
        checks++;
        if (spike_count !== 16'd0 || isi_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL quiet_state: got count=%0d valid=%b ovf=%b expected 0/0/0",
                     spike_count, isi_valid, overflow);
        end
    endtask

    task automatic test_isi_basic();
        int s0, p0;
        step(1'b1, -8'sd23, 1'b1, 1'b1, 1'b1);
        s0 = n_spk; p0 = n_pops;
        run(2, 1'b1, -8'sd23, 1'b1);
        step(1'b1, 8'sd25, 1'b1, 1'b0, 1'b1);
        run(10, 1'b1, -8'sd23, 1'b1);
        step(1'b1, 8'sd25, 1'b1, 1'b0, 1'b1);
        run(4, 1'b1, -8'sd23, 1'b1);
        checks++;
        if (n_spk - s0 != 2) begin
            errors++;
            $display("FAIL basic_spikes: got %0d expected 2", n_spk - s0);
        end
        checks++;
        if (n_pops - p0 != 1 || last_pop !== 16'd11) begin
            errors++;
            $display("FAIL basic_isi: got pops=%0d isi=%0d expected pops=1 isi=11", n_pops - p0, last_pop);
        end
        checks++;
        if (spike_count !== 16'd2) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 2", spike_count);
        end
    endtask

    task automatic test_no_rearm();
        int s0;
        step(1'b1, -8'sd23, 1'b1, 1'b1, 1'b1);
        s0 = n_spk;
        run(20, 1'b1, 8'sd25, 1'b1);
        run(10, 1'b1, 8'sd0, 1'b1);
        run(5, 1'b1, 8'sd25, 1'b1);
        checks++;
        if (n_spk - s0 != 1 || spike_count !== 16'd1 || isi_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_rearm: got spikes=%0d count=%0d valid=%b expected 1/1/0",
                     n_spk - s0, spike_count, isi_valid);
        end
    endtask

    task automatic test_overflow();
        int p0;
        step(1'b1, -8'sd23, 1'b0, 1'b1, 1'b1);
        spike_train(6, 1'b0);
        checks++;
        if (overflow !== 1'b1 || isi_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b valid=%b expected 1/1", overflow, isi_valid);
        end
        p0 = n_pops;
        run(6, 1'b1, -8'sd23, 1'b1);
        checks++;
        if (n_pops - p0 != 4 || last_pop !== 16'd5) begin
            errors++;
            $display("FAIL ovf_drain: got pops=%0d last=%0d expected 4/5", n_pops - p0, last_pop);
        end
        checks++;
        if (overflow !== 1'b1 || isi_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b valid=%b expected 1/0", overflow, isi_valid);
        end
        step(1'b1, -8'sd23, 1'b1, 1'b1, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b expected 0", overflow);
        end
    endtask

    task automatic test_en_gating();
        int s0;
        step(1'b1, -8'sd23, 1'b1, 1'b1, 1'b1);
        s0 = n_spk;
        step(1'b1, 8'sd25, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 8'sd25, 1'b1, 1'b0, 1'b1);
            step(1'b1, -8'sd23, 1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 8'sd25, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'sd25, 1'b1, 1'b0, 1'b1);
        run(3, 1'b1, -8'sd23, 1'b1);
        checks++;
        if (n_spk - s0 != 2 || last_pop !== 16'd8) begin
            errors++;
            $display("FAIL en_gating: got spikes=%0d isi=%0d expected 2/8", n_spk - s0, last_pop);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        step(1'b1, -8'sd23, 1'b0, 1'b1, 1'b1);
        spike_train(5, 1'b0);
        step(1'b1, 8'sd25, 1'b0, 1'b0, 1'b1);
        p0 = n_pops;
        step(1'b1, -8'sd23, 1'b1, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || isi_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: got ovf=%b valid=%b expected 0/1", overflow, isi_valid);
        end
        run(6, 1'b1, -8'sd23, 1'b1);
        checks++;
        if (n_pops - p0 != 5 || last_pop !== 16'd5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got pops=%0d last=%0d ovf=%b expected 5/5/0",
                     n_pops - p0, last_pop, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        step(1'b1, -8'sd23, 1'b0, 1'b1, 1'b1);
        spike_train(5, 1'b0);
        step(1'b1, 8'sd25, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'sd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'sd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (spike !== 1'b0 || spike_count !== 16'd0 || isi_valid !== 1'b0 ||
            isi_data !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got spike=%b count=%0d valid=%b data=%0d ovf=%b expected all 0",
                     spike, spike_count, isi_valid, isi_data, overflow);
        end
        s0 = n_spk;
        step(1'b1, 8'sd25, 1'b0, 1'b0, 1'b1);
        run(3, 1'b1, -8'sd23, 1'b0);
        checks++;
        if (n_spk - s0 != 1 || spike_count !== 16'd1 || isi_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_spike: got spikes=%0d count=%0d valid=%b expected 1/1/0",
                     n_spk - s0, spike_count, isi_valid);
        end
    endtask

    initial begin
        test_reset();
        test_isi_basic();
        test_no_rearm();
        test_overflow();
        test_en_gating();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
